// File: rtl/trs_rd_resp.sv
// trs_rd_resp: answers Z80 IN cycles on the LE18 data port (waits for pipeline data) and status port.
// Optional read timeout is enabled by defining RD_TIMEOUT_EN; the default build has no counter.
module trs_rd_resp #(
  parameter logic [7:0] PORT_DATA    = 8'hEC,
  parameter logic [7:0] PORT_STAT    = 8'hEF,
  parameter logic [7:0] WAIT_TIMEOUT = 8'd200
) (
  input  logic       clk,
  input  logic       srst,
  input  logic [7:0] TRS_A,
  input  logic       TRS_IN,
  input  logic [7:0] le18_dout,
  input  logic       le18_dout_rdy,
  input  logic       le18_enable,
  output logic       TRS_WAIT,
  output logic [7:0] TRS_DOUT,
  output logic       TRS_DOE,
  output logic       rd_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DATA,
    DRIVE
  } state_e;

  state_e     state_q;
  logic       s1_q;
  logic       s2_q;
  logic       s3_q;
  logic [7:0] data_q;
  logic       start;

  // TRS_IN is asynchronous; s3 delays s2 so a falling edge yields a one-cycle start.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= TRS_IN;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign start = ~s2_q & s3_q;

`ifdef RD_TIMEOUT_EN
  localparam logic [7:0] LastCount = WAIT_TIMEOUT - 8'd1;

  logic [7:0] count_q;
  logic       timeout_q;
  logic       expired;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      count_q <= 8'd0;
    end else if (state_q == IDLE && start && TRS_A == PORT_DATA) begin
      count_q <= 8'd0;
    end else if (state_q == WAIT_DATA && count_q != 8'hFF) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign expired    = (count_q == LastCount);
  assign rd_timeout = timeout_q;
`else
  logic unused_wait_timeout;

  assign unused_wait_timeout = ^WAIT_TIMEOUT;
  assign rd_timeout          = 1'b0;
`endif

  // An abort (strobe released) beats data, and arriving data beats the timeout.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q   <= IDLE;
      data_q    <= 8'h00;
`ifdef RD_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (TRS_A == PORT_DATA) begin
              state_q <= WAIT_DATA;
            end else if (TRS_A == PORT_STAT) begin
              state_q <= DRIVE;
              data_q  <= {7'b0, le18_enable};
            end
          end
        end
        WAIT_DATA: begin
          if (s2_q) begin
            state_q <= IDLE;
          end else if (le18_dout_rdy) begin
            state_q <= DRIVE;
            data_q  <= le18_dout;
          end
`ifdef RD_TIMEOUT_EN
          else if (expired) begin
            state_q   <= DRIVE;
            data_q    <= 8'hFF;
            timeout_q <= 1'b1;
          end
`endif
        end
        DRIVE: begin
          if (s2_q) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode the state register directly so reset releases the bus without a clock.
  assign TRS_WAIT = (state_q == WAIT_DATA);
  assign TRS_DOE  = (state_q == DRIVE);
  assign TRS_DOUT = (state_q == DRIVE) ? data_q : 8'h00;

endmodule

// File: doc/trs_rd_resp.md
TRS_RD_RESP -- requirements
Module: trs_rd_resp

Interface
REQ-001 SHALL have parameter PORT_DATA, default 8'hEC: IN port served from the LE18 read pipeline.
REQ-002 SHALL have parameter PORT_STAT, default 8'hEF: IN port served immediately with status.
REQ-003 SHALL have parameter WAIT_TIMEOUT, default 8'd200: maximum clocks spent in WAIT_DATA, legal range 1-255.
REQ-004 SHALL have port clk, input, 1: system clock; one clock domain.
REQ-005 SHALL have port srst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port TRS_A, input, 8: Z80 port address, low byte.
REQ-007 SHALL have port TRS_IN, input, 1: Z80 IN strobe, active-low, asynchronous to clk.
REQ-008 SHALL have port le18_dout, input, 8: read data from the LE18 graphics block.
REQ-009 SHALL have port le18_dout_rdy, input, 1: single-cycle strobe; le18_dout is valid in that cycle.
REQ-010 SHALL have port le18_enable, input, 1: LE18 options enable bit.
REQ-011 SHALL have port TRS_WAIT, output, 1: active-high wait request to the Z80 bus driver.
REQ-012 SHALL have port TRS_DOUT, output, 8: read data for the Z80 data bus.
REQ-013 SHALL have port TRS_DOE, output, 1: data-bus output enable.
REQ-014 SHALL have port rd_timeout, output, 1: sticky flag, set when any data read times out.

Function
REQ-015 SHALL synchronize TRS_IN through two flops (s1, s2) and hold a third flop s3; start = ~s2 & s3.
REQ-016 SHALL implement states IDLE, WAIT_DATA, DRIVE.
REQ-017 IDLE transitions on start:
  - TRS_A==PORT_DATA: go to WAIT_DATA and clear the counter.
  - TRS_A==PORT_STAT: go to DRIVE and load the data register with {7'b0, le18_enable}.
  - Any other address: stay in IDLE.
REQ-018 TRS_WAIT SHALL equal (state==WAIT_DATA), decoded directly from the state register.
  - Latency: TRS_WAIT rises on the third rising clk edge after TRS_IN is first sampled low.
REQ-019 In WAIT_DATA, the counter SHALL increment by one each clock.
REQ-020 In WAIT_DATA with le18_dout_rdy=1: capture le18_dout into the data register and go to DRIVE.
REQ-021 In WAIT_DATA with counter==WAIT_TIMEOUT-1 and no rdy: load 8'hFF, set rd_timeout, go to DRIVE.
REQ-022 If rdy and the timeout condition occur in the same cycle, rdy SHALL win and rd_timeout SHALL remain unchanged.
REQ-023 In WAIT_DATA with s2=1 (strobe aborted): go to IDLE and drive nothing; a later rdy SHALL be ignored.
REQ-024 TRS_DOE SHALL equal (state==DRIVE); TRS_DOUT SHALL equal the data register in DRIVE and 8'h00 otherwise.
REQ-025 DRIVE SHALL return to IDLE on the first cycle with s2=1; the data register SHALL hold its value.
REQ-026 le18_dout_rdy in IDLE or DRIVE SHALL be ignored.
REQ-027 A new start SHALL be recognized only in IDLE; back-to-back IN cycles require TRS_IN to return high between them.
REQ-028 TRS_A SHALL be sampled only in the start cycle.
REQ-029 The counter SHALL be 8 bits, SHALL not wrap, and SHALL be don't-care outside WAIT_DATA.

Reset
REQ-030 srst=1 SHALL asynchronously force:
  - state to IDLE;
  - s1, s2, s3 to 1;
  - counter, data register and rd_timeout to 0;
  - outputs TRS_WAIT=0, TRS_DOE=0, TRS_DOUT=8'h00, rd_timeout=0.
REQ-031 Reset asserted mid-transaction SHALL release TRS_WAIT and TRS_DOE in the same cycle, without waiting for a clock.
REQ-032 After srst falls, a TRS_IN already low SHALL be treated as a new start once it has propagated through s2.

Configuration
REQ-033 Macro RD_TIMEOUT_EN:
  - Defined: REQ-003, REQ-021 and REQ-022 apply.
  - Undefined: no counter; WAIT_DATA exits only on rdy or abort; rd_timeout is tied to 0.

Verification
REQ-034 IN port EC; rdy with 8'h5A 6 clocks after TRS_WAIT rises -> TRS_WAIT high exactly 6 clocks; DOE=1, DOUT=8'h5A until TRS_IN rises +2 clocks.
REQ-035 IN port EF with le18_enable=1 -> TRS_WAIT never asserts; DOUT=8'h01 with DOE=1.
REQ-036 IN port EC, no rdy, WAIT_TIMEOUT=200, macro defined -> TRS_WAIT high 200 clocks; DOUT=8'hFF; rd_timeout=1 and sticky.
REQ-037 IN port EC aborted after 3 wait clocks, then rdy pulses -> DOE stays 0; state IDLE; next EC read returns fresh data.
REQ-038 srst pulsed while in DRIVE -> DOE=0 and WAIT=0 immediately; IN port 3C -> no response.
REQ-039 rdy in the same cycle as counter==WAIT_TIMEOUT-1, data 8'h33 -> DOUT=8'h33; rd_timeout stays 0.
